// File: rtl/mul_result_buffer_if.sv
// rtl/mul_result_buffer_if.sv - multiplier result buffer handshake and status bundle
interface mul_result_buffer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_error;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_error;
  logic             out_overflow;
  logic             flag_clear;
  logic             sticky_error;
  logic             sticky_overflow;
  logic [CNT_W-1:0] err_count;
  logic [LW-1:0]    level;

  modport master (
    output in_valid, in_result, in_error, in_overflow, out_ready, flag_clear,
    input  in_ready, out_valid, out_result, out_error, out_overflow,
    input  sticky_error, sticky_overflow, err_count, level
  );

  modport slave (
    input  in_valid, in_result, in_error, in_overflow, out_ready, flag_clear,
    output in_ready, out_valid, out_result, out_error, out_overflow,
    output sticky_error, sticky_overflow, err_count, level
  );
endinterface

// File: rtl/mul_result_buffer.sv
// rtl/mul_result_buffer.sv - FIFO buffer for multiplier results with sticky flags
module mul_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  mul_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             sticky_err_q, sticky_err_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [33:0]      mem_q [DEPTH];

  logic        full, empty, push, pop;
  logic [33:0] head;

  // Ready/valid decode from registered level only, so no same-cycle bypass exists.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q + LW'(push) - LW'(pop);
    sticky_err_d = sticky_err_q;
    sticky_ovf_d = sticky_ovf_q;
    err_cnt_d    = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (bus.flag_clear) begin
      sticky_err_d = 1'b0;
      sticky_ovf_d = 1'b0;
      err_cnt_d    = '0;
    end
    // A push in the clear cycle is applied on top of the cleared value.
    if (push && bus.in_error) begin
      sticky_err_d = 1'b1;
      if (err_cnt_d != {CNT_W{1'b1}}) err_cnt_d = err_cnt_d + CNT_W'(1);
    end
    if (push && bus.in_overflow) sticky_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sticky_err_q <= 1'b0;
      sticky_ovf_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sticky_err_q <= sticky_err_d;
      sticky_ovf_q <= sticky_ovf_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_overflow, bus.in_error, bus.in_result};
  end

  assign bus.in_ready        = !full;
  assign bus.out_valid       = !empty;
  assign bus.out_result      = empty ? 32'h0 : head[31:0];
  assign bus.out_error       = empty ? 1'b0 : head[32];
  assign bus.out_overflow    = empty ? 1'b0 : head[33];
  assign bus.sticky_error    = sticky_err_q;
  assign bus.sticky_overflow = sticky_ovf_q;
  assign bus.err_count       = err_cnt_q;
  assign bus.level           = level_q;
endmodule

// File: tb/tb_mul_result_buffer.sv
// tb/tb_mul_result_buffer.sv - scoreboard bench for mul_result_buffer
module tb_mul_result_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus_if();

  mul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  logic [33:0] sb[$];
  int m_level;
  bit m_serr, m_sovf;
  int m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: occupancy and flags derived from accepted/popped entries.
  initial begin
    bit will_push, will_pop;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_level = 0; m_serr = 0; m_sovf = 0; m_cnt = 0;
        sb.delete();
      end else begin
        chk("level", 64'(bus_if.level), 64'(m_level));
        chk("in_ready", 64'(bus_if.in_ready), 64'(m_level != DEPTH));
        chk("out_valid", 64'(bus_if.out_valid), 64'(m_level != 0));
        chk("sticky_error", 64'(bus_if.sticky_error), 64'(m_serr));
        chk("sticky_overflow", 64'(bus_if.sticky_overflow), 64'(m_sovf));
        chk("err_count", 64'(bus_if.err_count), 64'(m_cnt));
        will_push = bus_if.in_valid && (m_level < DEPTH);
        will_pop  = bus_if.out_ready && (m_level > 0);
        if (will_push) sb.push_back({bus_if.in_overflow, bus_if.in_error, bus_if.in_result});
        if (bus_if.flag_clear) begin
          m_serr = 0; m_sovf = 0; m_cnt = 0;
        end
        if (will_push && bus_if.in_error) begin
          m_serr = 1;
          m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
        if (will_push && bus_if.in_overflow) m_sovf = 1;
        m_level = m_level + int'(will_push) - int'(will_pop);
      end
    end
  end

  // Monitor: compares each consumed head entry against the scoreboard front.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected: got %0h expected no entry", bus_if.out_result);
        end else begin
          e = sb.pop_front();
          chk("pop_data", {30'h0, bus_if.out_overflow, bus_if.out_error, bus_if.out_result}, 64'(e));
        end
      end else if (rst_n && !bus_if.out_valid) begin
        chk("idle_out_zero", {30'h0, bus_if.out_overflow, bus_if.out_error, bus_if.out_result}, 64'h0);
      end
    end
  end

  task automatic push1(input logic [31:0] r, input logic err, input logic ovf);
    bus_if.in_valid = 1'b1; bus_if.in_result = r;
    bus_if.in_error = err;  bus_if.in_overflow = ovf;
    step();
    bus_if.in_valid = 1'b0; bus_if.in_error = 1'b0; bus_if.in_overflow = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.in_valid = 1'b0; bus_if.in_result = '0; bus_if.in_error = 1'b0;
    bus_if.in_overflow = 1'b0; bus_if.out_ready = 1'b0; bus_if.flag_clear = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'h1);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'h0);
    chk("rst_level", 64'(bus_if.level), 64'h0);
    chk("rst_out_result", 64'(bus_if.out_result), 64'h0);
    rst_n = 1'b1;
    step();

    // single pass-through
    push1(32'h40C00000, 1'b0, 1'b0);
    chk("pt_result", 64'(bus_if.out_result), 64'h40C00000);
    chk("pt_level", 64'(bus_if.level), 64'h1);
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    chk("pt_drained_valid", 64'(bus_if.out_valid), 64'h0);
    chk("pt_drained_result", 64'(bus_if.out_result), 64'h0);

    // full / back-pressure
    for (int i = 1; i <= 4; i++) push1(32'(i), 1'b0, 1'b0);
    bus_if.in_valid = 1'b1; bus_if.in_result = 32'h5;
    step();
    chk("full_level", 64'(bus_if.level), 64'h4);
    chk("full_in_ready", 64'(bus_if.in_ready), 64'h0);
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    chk("after_pop_in_ready", 64'(bus_if.in_ready), 64'h1);
    chk("after_pop_level", 64'(bus_if.level), 64'h3);
    step();
    bus_if.in_valid = 1'b0;
    chk("refill_level", 64'(bus_if.level), 64'h4);
    bus_if.out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("order", 64'(bus_if.out_result), 64'(i));
      step();
    end
    bus_if.out_ready = 1'b0;

    // streaming with pointer wrap
    bus_if.out_ready = 1'b1; bus_if.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_if.in_result = $urandom;
      step();
      chk("stream_level_le1", 64'(bus_if.level <= 1), 64'h1);
    end
    bus_if.in_valid = 1'b0;
    step();
    bus_if.out_ready = 1'b0;
    chk("stream_empty", 64'(bus_if.level), 64'h0);

    // flags with NaN / infinity pass-through
    push1(32'h7FC00000, 1'b1, 1'b0);
    push1(32'h7F800000, 1'b1, 1'b1);
    chk("flag_serr", 64'(bus_if.sticky_error), 64'h1);
    chk("flag_sovf", 64'(bus_if.sticky_overflow), 64'h1);
    chk("flag_cnt", 64'(bus_if.err_count), 64'h2);
    chk("nan_result", 64'(bus_if.out_result), 64'h7FC00000);
    bus_if.out_ready = 1'b1;
    step();
    chk("inf_result", 64'(bus_if.out_result), 64'h7F800000);
    chk("inf_ovf", 64'(bus_if.out_overflow), 64'h1);
    step();

    // clear together with an error push, then saturation
    bus_if.flag_clear = 1'b1;
    push1(32'h3F800000, 1'b1, 1'b0);
    bus_if.flag_clear = 1'b0;
    chk("clr_serr", 64'(bus_if.sticky_error), 64'h1);
    chk("clr_cnt", 64'(bus_if.err_count), 64'h1);
    chk("clr_sovf", 64'(bus_if.sticky_overflow), 64'h0);
    for (int i = 0; i < 5; i++) push1(32'(i + 100), 1'b1, 1'b0);
    chk("sat_cnt", 64'(bus_if.err_count), 64'(CMAX));
    repeat (3) step();
    bus_if.out_ready = 1'b0;

    // randomized traffic; inputs held while stalled
    for (int i = 0; i < 400; i++) begin
      if (!(bus_if.in_valid && !bus_if.in_ready)) begin
        bus_if.in_valid    = ($urandom % 3) != 0;
        bus_if.in_result   = $urandom;
        bus_if.in_error    = ($urandom % 4) == 0;
        bus_if.in_overflow = ($urandom % 5) == 0;
      end
      bus_if.out_ready  = ($urandom % 2) == 0;
      bus_if.flag_clear = ($urandom % 16) == 0;
      step();
    end
    bus_if.in_valid = 1'b0; bus_if.flag_clear = 1'b0; bus_if.out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("rand_drained", 64'(sb.size()), 64'h0);
    bus_if.out_ready = 1'b0;

    // reset mid-stream
    push1(32'h40C00000, 1'b1, 1'b1);
    push1(32'h3F800000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus_if.out_valid), 64'h0);
    chk("midrst_level", 64'(bus_if.level), 64'h0);
    chk("midrst_serr", 64'(bus_if.sticky_error), 64'h0);
    chk("midrst_sovf", 64'(bus_if.sticky_overflow), 64'h0);
    chk("midrst_cnt", 64'(bus_if.err_count), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 64'(bus_if.in_ready), 64'h1);
    push1(32'h12345678, 1'b0, 1'b0);
    chk("postrst_result", 64'(bus_if.out_result), 64'h12345678);
    bus_if.out_ready = 1'b1;
    repeat (2) step();
    chk("final_drained", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
